// File: rtl/gaussian_pyramid_pkg.sv
// gaussian_pyramid_pkg: kernel weights, normalisation shift, octave geometry helpers and FSM states
package gaussian_pyramid_pkg;
  localparam int NORM_SHIFT = 4;
  localparam int KERNEL [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  function automatic int oct_dim(input int top, input int oct);
    return top >> oct;
  endfunction
  function automatic int oct_addr_w(input int tw, input int th, input int oct);
    return $clog2(oct_dim(tw, oct) * oct_dim(th, oct));
  endfunction
endpackage

// File: rtl/gaussian_pyramid_core_blur.sv
// blur_3x3_stream: raster-order 3x3 Gaussian blur with border pass-through and self-flush.
// Define GAUSS_ROUND_EN to round half up instead of truncating.
module blur_3x3_stream
  import gaussian_pyramid_pkg::*;
#(
  parameter int W = 64,
  parameter int H = 64,
  parameter int BIT_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [BIT_DEPTH-1:0]       in_pixel,
  output logic                       out_valid,
  output logic [$clog2(W*H)-1:0]     out_addr,
  output logic [BIT_DEPTH-1:0]       out_pixel
);
  localparam int AW = $clog2(W * H);
  localparam int LW = $clog2(W);
  localparam int SW = BIT_DEPTH + 4;
`ifdef GAUSS_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif
  localparam logic [AW:0] NP = (AW + 1)'(W * H);
  localparam logic [AW:0] LP = (AW + 1)'(W + 1);
  localparam logic [AW:0] FP = (AW + 1)'(W * H + W + 1);
  logic [AW:0] pos;
  logic [BIT_DEPTH-1:0] lb_a [W];
  logic [BIT_DEPTH-1:0] lb_b [W];
  logic [BIT_DEPTH-1:0] col1 [3];
  logic [BIT_DEPTH-1:0] col2 [3];
  logic [BIT_DEPTH-1:0] win [3][3];
  logic [LW-1:0] ptr;
  logic [AW-1:0] oidx;
  logic beat, emit, border;
  logic [SW-1:0] sum;
  // once all inputs are in, keep stepping the window to push out the last W+1 (border) results
  assign ptr = pos[LW-1:0];
  assign beat = (in_valid && pos < NP) || (pos >= NP && pos < FP);
  assign emit = beat && pos >= LP;
  assign oidx = AW'(pos - LP);
  assign border = oidx[AW-1:LW] == '0 || &oidx[AW-1:LW] || oidx[LW-1:0] == '0 || &oidx[LW-1:0];
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = col1[r];
      win[r][1] = col2[r];
    end
    win[0][2] = lb_b[ptr];
    win[1][2] = lb_a[ptr];
    win[2][2] = in_pixel;
    sum = SW'(RND);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum = sum + SW'(win[r][c]) * SW'(KERNEL[r][c]);
  end
  always_ff @(posedge clk) begin
    if (beat) begin
      lb_a[ptr] <= in_pixel;
      lb_b[ptr] <= lb_a[ptr];
      col1 <= col2;
      col2 <= '{lb_b[ptr], lb_a[ptr], in_pixel};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_pixel <= '0;
    end else begin
      pos <= clr ? '0 : beat ? pos + 1'b1 : pos;
      out_valid <= emit;
      if (emit) begin
        out_addr <= oidx;
        out_pixel <= border ? win[1][1] : sum[SW-1:NORM_SHIFT];
      end
    end
  end
endmodule

// File: rtl/gaussian_pyramid_core.sv
// gaussian_pyramid_core: one-pass 3-octave x 3-level Gaussian pyramid from a raster-read BRAM.
// Define GAUSS_ROUND_EN to make every blur round half up instead of truncating.
module gaussian_pyramid_core
  import gaussian_pyramid_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int TOP_WIDTH = 64,
  parameter int TOP_HEIGHT = 64,
  parameter int READ_LATENCY = 2,
  localparam int A1 = oct_addr_w(TOP_WIDTH, TOP_HEIGHT, 0),
  localparam int A2 = oct_addr_w(TOP_WIDTH, TOP_HEIGHT, 1),
  localparam int A3 = oct_addr_w(TOP_WIDTH, TOP_HEIGHT, 2)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [A1-1:0]        ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [A1-1:0]        O1L1_write_addr, O1L2_write_addr, O1L3_write_addr,
  output logic                 O1L1_write_valid, O1L2_write_valid, O1L3_write_valid,
  output logic [BIT_DEPTH-1:0] O1L1_pixel_out, O1L2_pixel_out, O1L3_pixel_out,
  output logic [A2-1:0]        O2L1_write_addr, O2L2_write_addr, O2L3_write_addr,
  output logic                 O2L1_write_valid, O2L2_write_valid, O2L3_write_valid,
  output logic [BIT_DEPTH-1:0] O2L1_pixel_out, O2L2_pixel_out, O2L3_pixel_out,
  output logic [A3-1:0]        O3L1_write_addr, O3L2_write_addr, O3L3_write_addr,
  output logic                 O3L1_write_valid, O3L2_write_valid, O3L3_write_valid,
  output logic [BIT_DEPTH-1:0] O3L1_pixel_out, O3L2_pixel_out, O3L3_pixel_out,
  output logic                 pyramid_done
);
  localparam int W2 = oct_dim(TOP_WIDTH, 1), H2 = oct_dim(TOP_HEIGHT, 1);
  localparam int W3 = oct_dim(TOP_WIDTH, 2), H3 = oct_dim(TOP_HEIGHT, 2);
  localparam int LW1 = $clog2(TOP_WIDTH), LW2 = $clog2(W2);
  state_t state, next;
  logic clr, keep2, keep3;
  logic [READ_LATENCY-1:0] vld_dly;
  logic [A1-1:0] addr_dly [READ_LATENCY];
  assign clr = state == IDLE && start_in;
  assign ext_read_addr_valid = state == READ;
  assign pyramid_done = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_in ? READ : IDLE;
      READ:    next = &ext_read_addr ? DRAIN : READ;
      DRAIN:   next = O3L3_write_valid && &O3L3_write_addr ? DONE : DRAIN;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      ext_read_addr <= '0;
    end else begin
      state <= next;
      ext_read_addr <= clr ? '0 : state == READ ? ext_read_addr + 1'b1 : ext_read_addr;
    end
  end
  // the BRAM answers READ_LATENCY cycles after the address, so the address rides alongside
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_dly <= '0;
      addr_dly <= '{default: '0};
      O1L1_write_valid <= 1'b0;
      O1L1_write_addr <= '0;
      O1L1_pixel_out <= '0;
    end else begin
      vld_dly[0] <= ext_read_addr_valid;
      addr_dly[0] <= ext_read_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_dly[i] <= vld_dly[i-1];
        addr_dly[i] <= addr_dly[i-1];
      end
      O1L1_write_valid <= vld_dly[READ_LATENCY-1];
      if (vld_dly[READ_LATENCY-1]) begin
        O1L1_write_addr <= addr_dly[READ_LATENCY-1];
        O1L1_pixel_out <= ext_pixel_in;
      end
    end
  end
  // decimators keep even rows and even columns; dropping the low row and col bits gives the new address
  assign keep2 = O1L3_write_valid && !O1L3_write_addr[LW1] && !O1L3_write_addr[0];
  assign keep3 = O2L3_write_valid && !O2L3_write_addr[LW2] && !O2L3_write_addr[0];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      O2L1_write_valid <= 1'b0;
      O2L1_write_addr <= '0;
      O2L1_pixel_out <= '0;
      O3L1_write_valid <= 1'b0;
      O3L1_write_addr <= '0;
      O3L1_pixel_out <= '0;
    end else begin
      O2L1_write_valid <= keep2;
      O3L1_write_valid <= keep3;
      if (keep2) begin
        O2L1_write_addr <= {O1L3_write_addr[A1-1:LW1+1], O1L3_write_addr[LW1-1:1]};
        O2L1_pixel_out <= O1L3_pixel_out;
      end
      if (keep3) begin
        O3L1_write_addr <= {O2L3_write_addr[A2-1:LW2+1], O2L3_write_addr[LW2-1:1]};
        O3L1_pixel_out <= O2L3_pixel_out;
      end
    end
  end
  blur_3x3_stream #(.W(TOP_WIDTH), .H(TOP_HEIGHT), .BIT_DEPTH(BIT_DEPTH)) u_b11 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O1L1_write_valid), .in_pixel(O1L1_pixel_out),
    .out_valid(O1L2_write_valid), .out_addr(O1L2_write_addr), .out_pixel(O1L2_pixel_out));
  blur_3x3_stream #(.W(TOP_WIDTH), .H(TOP_HEIGHT), .BIT_DEPTH(BIT_DEPTH)) u_b12 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O1L2_write_valid), .in_pixel(O1L2_pixel_out),
    .out_valid(O1L3_write_valid), .out_addr(O1L3_write_addr), .out_pixel(O1L3_pixel_out));
  blur_3x3_stream #(.W(W2), .H(H2), .BIT_DEPTH(BIT_DEPTH)) u_b21 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O2L1_write_valid), .in_pixel(O2L1_pixel_out),
    .out_valid(O2L2_write_valid), .out_addr(O2L2_write_addr), .out_pixel(O2L2_pixel_out));
  blur_3x3_stream #(.W(W2), .H(H2), .BIT_DEPTH(BIT_DEPTH)) u_b22 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O2L2_write_valid), .in_pixel(O2L2_pixel_out),
    .out_valid(O2L3_write_valid), .out_addr(O2L3_write_addr), .out_pixel(O2L3_pixel_out));
  blur_3x3_stream #(.W(W3), .H(H3), .BIT_DEPTH(BIT_DEPTH)) u_b31 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O3L1_write_valid), .in_pixel(O3L1_pixel_out),
    .out_valid(O3L2_write_valid), .out_addr(O3L2_write_addr), .out_pixel(O3L2_pixel_out));
  blur_3x3_stream #(.W(W3), .H(H3), .BIT_DEPTH(BIT_DEPTH)) u_b32 (
    .clk(clk_in), .rst_n(rst_in), .clr(clr),
    .in_valid(O3L2_write_valid), .in_pixel(O3L2_pixel_out),
    .out_valid(O3L3_write_valid), .out_addr(O3L3_write_addr), .out_pixel(O3L3_pixel_out));
endmodule

// File: tb/tb_gaussian_pyramid_core.sv
// tb_gaussian_pyramid_core: drives images through a 2-cycle BRAM model and checks all 9 streams
// against an arithmetic pyramid model; honours GAUSS_ROUND_EN like the design.
module tb_gaussian_pyramid_core;
  localparam int TW = 64, TH = 64, N1 = TW * TH;
  localparam int NL [9] = '{4096, 4096, 4096, 1024, 1024, 1024, 256, 256, 256};
`ifdef GAUSS_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif
  logic clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0;
  logic [11:0] ext_read_addr;
  logic ext_read_addr_valid;
  logic [7:0] ext_pixel_in, p0, p1;
  logic [11:0] O1L1_write_addr, O1L2_write_addr, O1L3_write_addr;
  logic [9:0] O2L1_write_addr, O2L2_write_addr, O2L3_write_addr;
  logic [7:0] O3L1_write_addr, O3L2_write_addr, O3L3_write_addr;
  logic O1L1_write_valid, O1L2_write_valid, O1L3_write_valid;
  logic O2L1_write_valid, O2L2_write_valid, O2L3_write_valid;
  logic O3L1_write_valid, O3L2_write_valid, O3L3_write_valid;
  logic [7:0] O1L1_pixel_out, O1L2_pixel_out, O1L3_pixel_out;
  logic [7:0] O2L1_pixel_out, O2L2_pixel_out, O2L3_pixel_out;
  logic [7:0] O3L1_pixel_out, O3L2_pixel_out, O3L3_pixel_out;
  logic pyramid_done;
  logic wv [9];
  logic [11:0] wa [9];
  logic [7:0] wp [9];
  int img [N1];
  int model [9][N1];
  int cap [9][N1];
  int cnt [9], ord_err [9];
  int done_cnt, done_cyc, last_cyc, rd_next, rd_err, run_done;
  int n_checks = 0, n_fail = 0;

  gaussian_pyramid_core dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .ext_read_addr(ext_read_addr), .ext_read_addr_valid(ext_read_addr_valid), .ext_pixel_in(ext_pixel_in),
    .O1L1_write_addr(O1L1_write_addr), .O1L2_write_addr(O1L2_write_addr), .O1L3_write_addr(O1L3_write_addr),
    .O1L1_write_valid(O1L1_write_valid), .O1L2_write_valid(O1L2_write_valid), .O1L3_write_valid(O1L3_write_valid),
    .O1L1_pixel_out(O1L1_pixel_out), .O1L2_pixel_out(O1L2_pixel_out), .O1L3_pixel_out(O1L3_pixel_out),
    .O2L1_write_addr(O2L1_write_addr), .O2L2_write_addr(O2L2_write_addr), .O2L3_write_addr(O2L3_write_addr),
    .O2L1_write_valid(O2L1_write_valid), .O2L2_write_valid(O2L2_write_valid), .O2L3_write_valid(O2L3_write_valid),
    .O2L1_pixel_out(O2L1_pixel_out), .O2L2_pixel_out(O2L2_pixel_out), .O2L3_pixel_out(O2L3_pixel_out),
    .O3L1_write_addr(O3L1_write_addr), .O3L2_write_addr(O3L2_write_addr), .O3L3_write_addr(O3L3_write_addr),
    .O3L1_write_valid(O3L1_write_valid), .O3L2_write_valid(O3L2_write_valid), .O3L3_write_valid(O3L3_write_valid),
    .O3L1_pixel_out(O3L1_pixel_out), .O3L2_pixel_out(O3L2_pixel_out), .O3L3_pixel_out(O3L3_pixel_out),
    .pyramid_done(pyramid_done));

  always #5 clk_in = ~clk_in;

  // single-port BRAM with two cycles of read latency
  always @(posedge clk_in) begin
    p0 <= ext_read_addr_valid ? 8'(img[ext_read_addr]) : 8'h00;
    p1 <= p0;
  end
  assign ext_pixel_in = p1;

  assign wv[0] = O1L1_write_valid; assign wa[0] = O1L1_write_addr; assign wp[0] = O1L1_pixel_out;
  assign wv[1] = O1L2_write_valid; assign wa[1] = O1L2_write_addr; assign wp[1] = O1L2_pixel_out;
  assign wv[2] = O1L3_write_valid; assign wa[2] = O1L3_write_addr; assign wp[2] = O1L3_pixel_out;
  assign wv[3] = O2L1_write_valid; assign wa[3] = 12'(O2L1_write_addr); assign wp[3] = O2L1_pixel_out;
  assign wv[4] = O2L2_write_valid; assign wa[4] = 12'(O2L2_write_addr); assign wp[4] = O2L2_pixel_out;
  assign wv[5] = O2L3_write_valid; assign wa[5] = 12'(O2L3_write_addr); assign wp[5] = O2L3_pixel_out;
  assign wv[6] = O3L1_write_valid; assign wa[6] = 12'(O3L1_write_addr); assign wp[6] = O3L1_pixel_out;
  assign wv[7] = O3L2_write_valid; assign wa[7] = 12'(O3L2_write_addr); assign wp[7] = O3L2_pixel_out;
  assign wv[8] = O3L3_write_valid; assign wa[8] = 12'(O3L3_write_addr); assign wp[8] = O3L3_pixel_out;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pyramid from the definition: copy, blur twice, decimate the third level into the next octave
  task automatic build_model();
    int w, h, s, src, idx;
    w = TW;
    h = TH;
    for (int i = 0; i < N1; i++) model[0][i] = img[i];
    for (int o = 0; o < 3; o++) begin
      if (o > 0)
        for (int r = 0; r < h; r++)
          for (int c = 0; c < w; c++) model[o*3][r*w+c] = model[o*3-1][(2*r)*(2*w) + 2*c];
      for (int k = 1; k < 3; k++) begin
        src = o * 3 + k - 1;
        for (int r = 0; r < h; r++)
          for (int c = 0; c < w; c++) begin
            idx = r * w + c;
            if (r == 0 || c == 0 || r == h - 1 || c == w - 1) model[src+1][idx] = model[src][idx];
            else begin
              s = RND;
              for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                  s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * model[src][(r+dr)*w + c + dc];
              model[src+1][idx] = s / 16;
            end
          end
      end
      w /= 2;
      h /= 2;
    end
  endtask

  task automatic run_pyramid(input int restart_at);
    int cyc = 0;
    run_done = 0;
    for (int l = 0; l < 9; l++) begin
      cnt[l] = 0;
      ord_err[l] = 0;
      for (int i = 0; i < N1; i++) cap[l][i] = -1;
    end
    done_cnt = 0; done_cyc = -1; last_cyc = -1; rd_next = 0; rd_err = 0;
    @(negedge clk_in) start_in = 1'b1;
    @(negedge clk_in) start_in = 1'b0;
    while (!run_done && cyc < 12000) begin
      if (ext_read_addr_valid) begin
        if (int'(ext_read_addr) != rd_next) rd_err++;
        rd_next++;
      end
      for (int l = 0; l < 9; l++)
        if (wv[l]) begin
          if (int'(wa[l]) != cnt[l]) ord_err[l]++;
          if (int'(wa[l]) < NL[l]) cap[l][wa[l]] = int'(wp[l]);
          cnt[l]++;
          if (l == 8 && int'(wa[l]) == 255) last_cyc = cyc;
        end
      if (pyramid_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      start_in = cyc == restart_at;
      if (done_cyc >= 0 && cyc > done_cyc + 4) run_done = 1;
      @(negedge clk_in);
      cyc++;
    end
    start_in = 1'b0;
  endtask

  task automatic verify(input string name);
    int cs_dut, cs_ref;
    check({name, " finished"}, run_done, 1);
    check({name, " read count"}, rd_next, N1);
    check({name, " read order errs"}, rd_err, 0);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " done delay"}, done_cyc - last_cyc, 1);
    for (int l = 0; l < 9; l++) begin
      cs_dut = 0;
      cs_ref = 0;
      for (int i = 0; i < NL[l]; i++) begin
        cs_dut = cs_dut * 31 + cap[l][i] + 1;
        cs_ref = cs_ref * 31 + model[l][i] + 1;
      end
      check($sformatf("%s O%0dL%0d writes", name, l / 3 + 1, l % 3 + 1), cnt[l], NL[l]);
      check($sformatf("%s O%0dL%0d addr order", name, l / 3 + 1, l % 3 + 1), ord_err[l], 0);
      check($sformatf("%s O%0dL%0d pixel sum", name, l / 3 + 1, l % 3 + 1), cs_dut, cs_ref);
    end
  endtask

  initial begin
    int r, c, dones, vsum;
    repeat (3) @(negedge clk_in);
    vsum = 0;
    for (int l = 0; l < 9; l++) vsum += int'(wv[l]);
    check("reset valids", vsum + int'(ext_read_addr_valid), 0);
    check("reset done", pyramid_done, 0);
    check("reset read addr", ext_read_addr, 0);
    check("reset O3L3 addr", O3L3_write_addr, 0);
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int i = 0; i < N1; i++) img[i] = 100;
    build_model();
    run_pyramid(-1);
    verify("const");
    check("const O3L3 px", cap[8][137], 100);
    check("const O1L2 px", cap[1][2000], 100);

    for (int i = 0; i < N1; i++) img[i] = 0;
    img[10*64+10] = 160;
    build_model();
    run_pyramid(-1);
    verify("impulse");
    check("impulse O1L2 (10,10)", cap[1][10*64+10], 40);
    check("impulse O1L2 (10,11)", cap[1][10*64+11], 20);
    check("impulse O1L2 (11,11)", cap[1][11*64+11], 10);
    check("impulse O1L3 (10,10)", cap[2][10*64+10], RND == 8 ? 23 : 22);

    for (int i = 0; i < N1; i++) img[i] = 0;
    img[0] = 200;
    build_model();
    run_pyramid(-1);
    verify("corner");
    check("corner O1L2 (0,0)", cap[1][0], 200);
    check("corner O1L2 (1,1)", cap[1][65], RND == 8 ? 13 : 12);

    for (int i = 0; i < N1; i++) img[i] = (i % TW) * 4;
    build_model();
    run_pyramid(-1);
    verify("ramp");
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 31);
      c = $urandom_range(0, 31);
      check($sformatf("ramp O2L1 (%0d,%0d)", r, c), cap[3][r*32+c], model[2][(2*r)*64 + 2*c]);
    end

    for (int i = 0; i < N1; i++) img[i] = $urandom_range(0, 255);
    build_model();
    run_pyramid(100);
    verify("random restart-ignored");
    run_pyramid(-1);
    verify("random rerun");

    @(negedge clk_in) start_in = 1'b1;
    @(negedge clk_in) start_in = 1'b0;
    repeat (500) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    vsum = 0;
    for (int l = 0; l < 9; l++) vsum += int'(wv[l]);
    check("midrun reset valids", vsum + int'(ext_read_addr_valid), 0);
    check("midrun reset addr", ext_read_addr, 0);
    @(negedge clk_in);
    vsum = 0;
    for (int l = 0; l < 9; l++) vsum += int'(wv[l]);
    check("midrun reset valids next", vsum, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    dones = 0;
    repeat (6000) begin
      @(negedge clk_in);
      dones += int'(pyramid_done);
    end
    check("midrun reset no done", dones, 0);

    for (int i = 0; i < N1; i++) img[i] = ((i / TW) * 7 + $urandom_range(0, 40)) % 256;
    build_model();
    run_pyramid(-1);
    verify("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
